// File: rtl/node_pkg.sv
// Shared definitions for operation-tree nodes: operation codes, FSM state
// encoding and the default datapath width.
package node_pkg;

    localparam int unsigned NODE_WIDTH = 16;

    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_MONUS = 1;
    localparam int unsigned OP_MUL   = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_EXEC
    } node_state_t;

endpackage

// File: rtl/node_mul_seq.sv
// Sequential shift-add multiplier: loads on start, then WIDTH iterations.
// done/prod are combinational during the last iteration so the caller can
// register the product on that same edge.
module node_mul_seq import node_pkg::*; #(
    parameter int unsigned WIDTH = NODE_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    assign prod = acc_next;
    assign done = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/node_join2.sv
// Two-input combining tree node: starts both children, joins on both ready,
// applies OP. Define NODE_TIMEOUT_EN to bound the child wait by TIMEOUT cycles.
module node_join2 import node_pkg::*; #(
    parameter int unsigned WIDTH   = NODE_WIDTH,
    parameter int unsigned OP      = OP_ADD,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ST,
    output logic             RD,
    output logic [WIDTH-1:0] RES,
    output logic             CST,
    input  logic             CRD0,
    input  logic             CRD1,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ERR
);

    node_state_t      state;
    logic             st_old;
    logic             start;
    logic             both_rdy;
    logic             capture;
    logic             exec_done;
    logic [WIDTH-1:0] exec_res;

    assign start    = ST & ~st_old;
    assign both_rdy = CRD0 & CRD1;
    assign capture  = (state == S_WAIT) && both_rdy;

    generate
        if (OP == OP_MUL) begin : g_mul
            logic             mul_done;
            logic [WIDTH-1:0] mul_prod;

            // Operands go straight into the multiplier on the capture edge.
            node_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .CLK   (CLK),
                .RST   (RST),
                .start (capture),
                .a     (A),
                .b     (B),
                .done  (mul_done),
                .prod  (mul_prod)
            );

            assign exec_done = mul_done;
            assign exec_res  = mul_prod;
        end else begin : g_alu
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] alu_res;

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (capture) begin
                    a_q <= A;
                    b_q <= B;
                end
            end

            always_comb begin
                alu_res = a_q + b_q;
                if (OP == OP_MONUS) begin
                    alu_res = (a_q >= b_q) ? (a_q - b_q) : '0;
                end
            end

            assign exec_done = 1'b1;
            assign exec_res  = alu_res;
        end
    endgenerate

`ifdef NODE_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);

    logic [TCW-1:0] tcnt;
    logic           err_q;
    logic           timed_out;

    assign timed_out = (tcnt == TCW'(TIMEOUT - 1));
    assign ERR       = err_q;
`else
    assign ERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= S_IDLE;
            st_old <= 1'b0;
            RD     <= 1'b1;
            RES    <= '0;
            CST    <= 1'b0;
`ifdef NODE_TIMEOUT_EN
            tcnt   <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            st_old <= ST;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        RD    <= 1'b0;
                        CST   <= 1'b1;
                        state <= S_ISSUE;
`ifdef NODE_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                    end
                end
                S_ISSUE: begin
                    CST   <= 1'b0;
                    state <= S_ARM;
                end
                // Children still show their stale ready here; skip one cycle.
                S_ARM: begin
                    state <= S_WAIT;
`ifdef NODE_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                S_WAIT: begin
                    if (both_rdy) begin
                        state <= S_EXEC;
                    end
`ifdef NODE_TIMEOUT_EN
                    else if (timed_out) begin
                        RES   <= '1;
                        err_q <= 1'b1;
                        RD    <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                S_EXEC: begin
                    if (exec_done) begin
                        RES   <= exec_res;
                        RD    <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_node_join2.sv
// Bench for node_join2: ADD, MONUS and MUL instances run in lockstep against a
// scoreboard; a fourth ADD instance with TIMEOUT=8 covers the child-wait limit.
module tb_node_join2;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST;
    logic         ST;
    logic         st_to;
    logic         CRD0;
    logic         CRD1;
    logic         crd1_to;
    logic [W-1:0] A;
    logic [W-1:0] B;

    logic         rd  [4];
    logic [W-1:0] res [4];
    logic         cst [4];
    logic         err [4];

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];
    logic [W-1:0] q2 [$];
    logic [W-1:0] q3 [$];
    logic [W-1:0] last [4];
    string        nm [4] = '{"add", "monus", "mul", "tmo"};

    always #5 CLK = ~CLK;

    node_join2 #(.WIDTH(W), .OP(0)) u_add (
        .CLK(CLK), .RST(RST), .ST(ST), .RD(rd[0]), .RES(res[0]), .CST(cst[0]),
        .CRD0(CRD0), .CRD1(CRD1), .A(A), .B(B), .ERR(err[0]));
    node_join2 #(.WIDTH(W), .OP(1)) u_mon (
        .CLK(CLK), .RST(RST), .ST(ST), .RD(rd[1]), .RES(res[1]), .CST(cst[1]),
        .CRD0(CRD0), .CRD1(CRD1), .A(A), .B(B), .ERR(err[1]));
    node_join2 #(.WIDTH(W), .OP(2)) u_mul (
        .CLK(CLK), .RST(RST), .ST(ST), .RD(rd[2]), .RES(res[2]), .CST(cst[2]),
        .CRD0(CRD0), .CRD1(CRD1), .A(A), .B(B), .ERR(err[2]));
    node_join2 #(.WIDTH(W), .OP(0), .TIMEOUT(8)) u_tmo (
        .CLK(CLK), .RST(RST), .ST(st_to), .RD(rd[3]), .RES(res[3]), .CST(cst[3]),
        .CRD0(CRD0), .CRD1(crd1_to), .A(A), .B(B), .ERR(err[3]));

    task automatic push_exp(input int i, input logic [W-1:0] v);
        case (i)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int i, output logic [W-1:0] v, output bit ok);
        ok = 1'b1;
        v  = '0;
        case (i)
            0: if (q0.size() == 0) ok = 1'b0; else v = q0.pop_front();
            1: if (q1.size() == 0) ok = 1'b0; else v = q1.pop_front();
            2: if (q2.size() == 0) ok = 1'b0; else v = q2.pop_front();
            default: if (q3.size() == 0) ok = 1'b0; else v = q3.pop_front();
        endcase
    endtask

    // One job on the three lockstep instances. Children drop ready after E1;
    // child0/child1 raise it after edge r0/r1 (3 = standard node latency).
    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int r0, input int r1, input bit tog, input int rst_at);
        logic [2*W-1:0] p;
        logic [W-1:0]   v;
        bit             ok;
        int             c;
        int             dn [3];
        c     = ((r0 > r1) ? r0 : r1) + 1;
        dn[0] = c + 1;
        dn[1] = c + 1;
        dn[2] = c + W;
        p     = a * b;
        push_exp(0, a + b);
        push_exp(1, (a >= b) ? (a - b) : '0);
        push_exp(2, p[W-1:0]);
        A  = 16'hDEAD;
        B  = 16'hBEEF;
        ST = 1'b1;
        @(posedge CLK);
        for (int e = 0; e <= c + W; e++) begin
            @(negedge CLK);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (e == 0) begin
                    if (rd[i] !== 1'b0 || cst[i] !== 1'b1 || res[i] !== last[i] || err[i] !== 1'b0) begin
                        bad++;
                        $display("FAIL start_%s: rd=%b cst=%b res=%h err=%b, want rd=0 cst=1 res=%h err=0",
                                 nm[i], rd[i], cst[i], res[i], err[i], last[i]);
                    end
                end else if (e < dn[i]) begin
                    if (rd[i] !== 1'b0 || cst[i] !== 1'b0 || res[i] !== last[i]) begin
                        bad++;
                        $display("FAIL busy_%s e=%0d: rd=%b cst=%b res=%h, want rd=0 cst=0 res=%h",
                                 nm[i], e, rd[i], cst[i], res[i], last[i]);
                    end
                end else if (e == dn[i]) begin
                    pop_exp(i, v, ok);
                    if (!ok || rd[i] !== 1'b1 || res[i] !== v || cst[i] !== 1'b0) begin
                        bad++;
                        $display("FAIL done_%s e=%0d: rd=%b res=%h cst=%b, want rd=1 res=%h cst=0",
                                 nm[i], e, rd[i], res[i], cst[i], v);
                    end
                    last[i] = v;
                end else begin
                    if (rd[i] !== 1'b1 || cst[i] !== 1'b0 || res[i] !== last[i]) begin
                        bad++;
                        $display("FAIL idle_%s e=%0d: rd=%b cst=%b res=%h, want rd=1 cst=0 res=%h",
                                 nm[i], e, rd[i], cst[i], res[i], last[i]);
                    end
                end
            end
            if (e == 1) begin
                CRD0 = 1'b0;
                CRD1 = 1'b0;
            end
            if (e == r0) CRD0 = 1'b1;
            if (e == r1) begin
                CRD1 = 1'b1;
                A    = a;
                B    = b;
            end
            if (tog && e == 5) ST = 1'b0;
            if (tog && e == 6) ST = 1'b1;
            if (rst_at != 0 && e == rst_at) begin
                RST = 1'b0;
                ST  = 1'b0;
                #1;
                for (int i = 0; i < 4; i++) begin
                    total++;
                    if (rd[i] !== 1'b1 || res[i] !== '0 || cst[i] !== 1'b0 || err[i] !== 1'b0) begin
                        bad++;
                        $display("FAIL rst_mid_%s: rd=%b res=%h cst=%b err=%b, want rd=1 res=0 cst=0 err=0",
                                 nm[i], rd[i], res[i], cst[i], err[i]);
                    end
                    last[i] = '0;
                end
                for (int i = 0; i < 3; i++) begin
                    if (e < dn[i]) pop_exp(i, v, ok);
                end
                #1;
                RST = 1'b1;
                @(negedge CLK);
                return;
            end
        end
        ST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b0; ST = 1'b0; st_to = 1'b0;
        CRD0 = 1'b1; CRD1 = 1'b1; crd1_to = 1'b1;
        A = '0; B = '0;
        #12;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd[i] !== 1'b1 || res[i] !== '0 || cst[i] !== 1'b0 || err[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_%s: rd=%b res=%h cst=%b err=%b, want rd=1 res=0 cst=0 err=0",
                         nm[i], rd[i], res[i], cst[i], err[i]);
            end
            last[i] = '0;
        end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_ops();
        logic [W-1:0] ta [6] = '{16'h0005, 16'h0009, 16'h0003, 16'h0100, 16'hFFFF, 16'h0007};
        logic [W-1:0] tb [6] = '{16'h0007, 16'h0003, 16'h0009, 16'h0101, 16'h0002, 16'h0007};
        for (int k = 0; k < 6; k++) run_job(ta[k], tb[k], 3, 3, 1'b0, 0);
    endtask

    task automatic test_skew_and_busy();
        run_job(16'h1234, 16'h0F00, 3, 13, 1'b1, 0);
        run_job(16'h0F00, 16'h1234, 12, 3, 1'b0, 0);
    endtask

    task automatic test_reset_mid_mul();
        run_job(16'h00FF, 16'h0003, 3, 3, 1'b0, 10);
        run_job(16'h0102, 16'h0201, 3, 3, 1'b0, 0);
    endtask

    task automatic test_timeout();
        logic [W-1:0] v;
        bit           ok;
        int           hold;
`ifdef NODE_TIMEOUT_EN
        hold = 10;
        push_exp(3, 16'hFFFF);
`else
        hold = 30;
        push_exp(3, 16'h0011);
`endif
        A = 16'h0008; B = 16'h0009;
        st_to = 1'b1;
        @(posedge CLK);
        for (int e = 0; e <= hold + 2; e++) begin
            @(negedge CLK);
            total++;
            if (e == 0) begin
                if (rd[3] !== 1'b0 || cst[3] !== 1'b1) begin
                    bad++;
                    $display("FAIL tmo_start: rd=%b cst=%b, want rd=0 cst=1", rd[3], cst[3]);
                end
`ifdef NODE_TIMEOUT_EN
            end else if (e < hold) begin
                if (rd[3] !== 1'b0 || err[3] !== 1'b0) begin
                    bad++;
                    $display("FAIL tmo_wait e=%0d: rd=%b err=%b, want rd=0 err=0", e, rd[3], err[3]);
                end
            end else if (e == hold) begin
                pop_exp(3, v, ok);
                if (!ok || rd[3] !== 1'b1 || err[3] !== 1'b1 || res[3] !== v) begin
                    bad++;
                    $display("FAIL tmo_fire: rd=%b err=%b res=%h, want rd=1 err=1 res=%h", rd[3], err[3], res[3], v);
                end
                last[3] = v;
            end else begin
                if (rd[3] !== 1'b1 || err[3] !== 1'b1 || res[3] !== last[3]) begin
                    bad++;
                    $display("FAIL tmo_hold e=%0d: rd=%b err=%b res=%h, want rd=1 err=1 res=%h",
                             e, rd[3], err[3], res[3], last[3]);
                end
            end
`else
            end else if (e <= hold + 1) begin
                if (rd[3] !== 1'b0 || err[3] !== 1'b0) begin
                    bad++;
                    $display("FAIL tmo_wait e=%0d: rd=%b err=%b, want rd=0 err=0", e, rd[3], err[3]);
                end
            end else begin
                pop_exp(3, v, ok);
                if (!ok || rd[3] !== 1'b1 || err[3] !== 1'b0 || res[3] !== v) begin
                    bad++;
                    $display("FAIL tmo_done: rd=%b err=%b res=%h, want rd=1 err=0 res=%h", rd[3], err[3], res[3], v);
                end
                last[3] = v;
            end
`endif
            if (e == 1) begin
                CRD0 = 1'b0;
                crd1_to = 1'b0;
            end
            if (e == 3) CRD0 = 1'b1;
            if (e == hold) crd1_to = 1'b1;
        end
        st_to = 1'b0;
        crd1_to = 1'b1;
        @(negedge CLK);
        // Follow-up job: error must clear on start and the node must work normally.
        push_exp(3, 16'h0030);
        A = 16'h0010; B = 16'h0020;
        st_to = 1'b1;
        @(posedge CLK);
        for (int e = 0; e <= 5; e++) begin
            @(negedge CLK);
            if (e == 0 || e == 5) begin
                total++;
                if (e == 0 && (err[3] !== 1'b0 || rd[3] !== 1'b0)) begin
                    bad++;
                    $display("FAIL tmo_clear: err=%b rd=%b, want err=0 rd=0", err[3], rd[3]);
                end
                if (e == 5) begin
                    pop_exp(3, v, ok);
                    if (!ok || rd[3] !== 1'b1 || err[3] !== 1'b0 || res[3] !== v) begin
                        bad++;
                        $display("FAIL tmo_rerun: rd=%b err=%b res=%h, want rd=1 err=0 res=%h", rd[3], err[3], res[3], v);
                    end
                    last[3] = v;
                end
            end
            if (e == 1) begin
                CRD0 = 1'b0;
                crd1_to = 1'b0;
            end
            if (e == 3) begin
                CRD0 = 1'b1;
                crd1_to = 1'b1;
            end
        end
        st_to = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_ops();
        test_skew_and_busy();
        test_reset_mid_mul();
        test_timeout();
        total++;
        if (q0.size() + q1.size() + q2.size() + q3.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d, want 0", q0.size() + q1.size() + q2.size() + q3.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/node_join2.md
# node_join2

Two-input combining node for the operation-tree datapath. It sits directly upstream of leaf/projection nodes: it forwards its own start to two child nodes, waits for both to report ready, captures their 16-bit results and applies a configured arithmetic operation. It exposes the same ST/RD/RES handshake as every tree node, so its parent treats it like any other node.

## Interface
Parameters:
- WIDTH, 16, datapath width of operands and RES
- OP, 0, operation: 0 = ADD (mod 2^WIDTH), 1 = MONUS (A>=B ? A-B : 0), 2 = MUL (low WIDTH bits, sequential)
- TIMEOUT, 1024, child wait limit in cycles (used only with NODE_TIMEOUT_EN)

Ports:
- CLK  in  1  single clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- ST  in  1  start from parent; a 0→1 transition sampled on CLK starts a job
- RD  out  1  ready: 1 = idle / RES valid, 0 = busy
- RES  out  WIDTH  result, registered
- CST  out  1  start pulse to both children
- CRD0, CRD1  in  1  child ready flags
- A, B  in  WIDTH  child results (A from child 0, B from child 1)
- ERR  out  1  child timeout flag

## Operation
- Reset (RST=0, asynchronous): state IDLE, RD=1, RES=0, CST=0, ERR=0, ST edge history cleared to 0.
- ST edge detect: registered STold; start = ST & ~STold. STold updated every cycle.
- States: IDLE → ISSUE → ARM → WAIT → EXEC → IDLE.
- IDLE: on start: RD←0, ERR←0, CST←1, go ISSUE.
- ISSUE (1 cycle, CST=1): CST←0, go ARM.
- ARM (1 cycle): CRD0/CRD1 ignored (children still show stale ready). Go WAIT.
- WAIT: when CRD0 & CRD1 both 1 in same cycle: capture A, B; go EXEC. One child ready alone: keep waiting.
- EXEC: ADD/MONUS complete in 1 cycle; MUL runs WIDTH shift-add iterations. On final edge: RES←result, RD←1, go IDLE.
- MONUS: result 0 whenever B>A; A=B gives 0.
- ADD/MUL overflow: truncated to WIDTH bits, no flag.
- start while not IDLE: ignored, no restart, STold still tracks.
- RES holds last result until next completion; not cleared at start.

## Timing
- Edge E0 samples start: RD=0 after E0; CST=1 during cycle E0–E1; children see ST rising at E1.
- With standard nodes (RD low at E1, high at E3): join captures at E4.
- RD=1 and RES valid after E5 (ADD/MONUS), after E4+WIDTH (MUL; E20 for WIDTH=16).
- General: capture edge = first WAIT edge with both ready; +1 (ADD/MONUS) or +WIDTH (MUL) to RD=1.
- CST is exactly one cycle wide per job.
- RST asserted mid-job: immediate return to reset values; children not signalled.

## Configuration
- NODE_TIMEOUT_EN defined: cycle counter runs in WAIT; reaching TIMEOUT cycles without both ready → RES←all ones, ERR←1, RD←1, go IDLE. ERR cleared at next start.
- Not defined: no counter, WAIT unbounded, ERR tied 0.

## Structure
- Package node_pkg: OP encodings (OP_ADD, OP_MONUS, OP_MUL), state enum, default WIDTH.
- Sub-module node_mul_seq: start/done shift-add multiplier, WIDTH iterations, used only when OP=2.
- Top FSM, edge detect, timeout counter in node_join2.

## Test plan
- OP=0, A=0x0005, B=0x0007, children standard latency → RD low after E0, CST one cycle, RES=0x000C, RD=1 after E5.
- OP=1, A=3, B=9 → RES=0; A=9, B=3 → RES=6.
- OP=2, A=0x0100, B=0x0101 → RES=0x0100 (truncated), RD=1 after E20.
- CRD0 high 10 cycles before CRD1 → capture only when both high; ST toggled while busy → no second CST, result unchanged.
- RST pulsed low in EXEC of MUL → RD=1, RES=0, CST=0 immediately; next ST edge runs normally.
- NODE_TIMEOUT_EN, TIMEOUT=8, CRD1 held 0 → after 8 WAIT cycles RES=0xFFFF, ERR=1, RD=1; next start clears ERR.
